// File: rtl/image_loader_pkg.sv
// rtl/image_loader_pkg.sv - shared image geometry defaults and loader state encodings
package image_loader_pkg;

   localparam int IMG_ROWS = 200;
   localparam int IMG_COLS = 320;
   localparam int ADDR_W   = 9;
   localparam int DATA_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } load_state_t;

   // Total number of pixel writes that make up one frame
   function automatic int pixel_count(input int rows, input int cols);
      return rows * cols;
   endfunction

endpackage

// File: rtl/image_loader_raster_counter.sv
// rtl/image_loader_raster_counter.sv - row/column raster position counter with final-pixel flag
module raster_counter
   import image_loader_pkg::*;
#(
   parameter int ROWS = IMG_ROWS,
   parameter int COLS = IMG_COLS,
   parameter int AW   = ADDR_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          advance,
   output logic [AW-1:0] row,
   output logic [AW-1:0] col,
   output logic          last
);

   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
   localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);

   logic row_end;
   logic col_end;

   assign row_end = (row == LAST_ROW);
   assign col_end = (col == LAST_COL);
   assign last    = row_end && col_end;

   // Clear wins over advance; advancing past the final pixel wraps to (0,0)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/image_loader.sv
// rtl/image_loader.sv - raster pixel stream to input-memory write port
module image_loader #(
   parameter int IMG_ROWS = image_loader_pkg::IMG_ROWS,
   parameter int IMG_COLS = image_loader_pkg::IMG_COLS,
   parameter int ADDR_W   = image_loader_pkg::ADDR_W,
   parameter int DATA_W   = image_loader_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] input_data,
   output logic [ADDR_W-1:0] wrow,
   output logic [ADDR_W-1:0] wcol,
   output logic              we,
   output logic              busy,
   output logic              frame_done
);

   import image_loader_pkg::*;

   load_state_t       state;
   logic              accept;
   logic              cnt_clear;
   logic              cnt_last;
   logic [ADDR_W-1:0] cnt_row;
   logic [ADDR_W-1:0] cnt_col;

   // in_ready is only ever high in LOAD, so this is the only acceptance path
   assign accept    = in_valid && in_ready && (state == ST_LOAD);
   assign cnt_clear = start && ((state == ST_IDLE) || (state == ST_DONE));

   raster_counter #(
      .ROWS (IMG_ROWS),
      .COLS (IMG_COLS),
      .AW   (ADDR_W)
   ) u_raster_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (cnt_clear),
      .advance (accept),
      .row     (cnt_row),
      .col     (cnt_col),
      .last    (cnt_last)
   );

   // Frame FSM with registered handshake, status and write-port outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         we         <= 1'b0;
         input_data <= '0;
         wrow       <= '0;
         wcol       <= '0;
      end else begin
         we <= 1'b0;
         if (accept) begin
            we         <= 1'b1;
            input_data <= in_data;
            wrow       <= cnt_row;
            wcol       <= cnt_col;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_LOAD;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_LOAD: begin
               // Drop in_ready together with the transition so the final pixel is the last beat taken
               if (accept && cnt_last) begin
                  state    <= ST_FLUSH;
                  in_ready <= 1'b0;
               end
            end
            ST_FLUSH: begin
               state      <= ST_DONE;
               busy       <= 1'b0;
               frame_done <= 1'b1;
            end
            ST_DONE: begin
               if (start) begin
                  state      <= ST_LOAD;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  frame_done <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - scoreboard bench for image_loader on a 3x4 and a 200x320 frame
module tb_image_loader;

   localparam int S_ROWS = 3;
   localparam int S_COLS = 4;
   localparam int B_ROWS = 200;
   localparam int B_COLS = 320;

   typedef struct {
      int r;
      int c;
      int d;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       s_rst_n = 1'b0, s_start = 1'b0, s_valid = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_ready, s_we, s_busy, s_done;
   logic [7:0] s_wdata;
   logic [8:0] s_wrow, s_wcol;

   logic       b_rst_n = 1'b0, b_start = 1'b0, b_valid = 1'b0;
   logic [7:0] b_data = '0;
   logic       b_ready, b_we, b_busy, b_done;
   logic [7:0] b_wdata;
   logic [8:0] b_wrow, b_wcol;

   image_loader #(.IMG_ROWS(S_ROWS), .IMG_COLS(S_COLS), .ADDR_W(9), .DATA_W(8)) u_small (
      .clk(clk), .rst_n(s_rst_n), .start(s_start), .in_data(s_data), .in_valid(s_valid),
      .in_ready(s_ready), .input_data(s_wdata), .wrow(s_wrow), .wcol(s_wcol), .we(s_we),
      .busy(s_busy), .frame_done(s_done));

   image_loader #(.IMG_ROWS(B_ROWS), .IMG_COLS(B_COLS), .ADDR_W(9), .DATA_W(8)) u_big (
      .clk(clk), .rst_n(b_rst_n), .start(b_start), .in_data(b_data), .in_valid(b_valid),
      .in_ready(b_ready), .input_data(b_wdata), .wrow(b_wrow), .wcol(b_wcol), .we(b_we),
      .busy(b_busy), .frame_done(b_done));

   wr_t s_q[$];
   wr_t b_q[$];
   int  s_idx = 0;
   int  b_idx = 0;
   int  s_writes = 0;
   int  b_writes = 0;
   int  b_last_r = -1;
   int  b_last_c = -1;
   logic s_done_due = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Small-frame monitor: every write must match the oldest accepted beat
   always @(negedge clk) begin
      if (!s_rst_n) begin
         s_q.delete();
         s_done_due = 1'b0;
      end else begin
         if (s_done_due) begin
            check("small_done_after_last", {31'd0, s_done}, 1);
            check("small_idle_after_last", {31'd0, s_busy}, 0);
            s_done_due = 1'b0;
         end
         if (s_we) begin
            if (s_q.size() == 0) begin
               check("small_unexpected_write", 1, 0);
            end else begin
               wr_t e;
               e = s_q.pop_front();
               check("small_write", {7'd0, s_wrow, 7'd0, s_wcol, s_wdata},
                     {7'd0, 9'(e.r), 7'd0, 9'(e.c), 8'(e.d)});
               check("small_done_low_in_frame", {31'd0, s_done}, 0);
               s_writes++;
               if (e.r == S_ROWS - 1 && e.c == S_COLS - 1) s_done_due = 1'b1;
            end
         end
      end
   end

   // Large-frame monitor: raster order, data and address range on every write
   always @(negedge clk) begin
      if (b_rst_n && b_we) begin
         check("big_in_range", {31'd0, (b_wrow < 9'(B_ROWS)) && (b_wcol < 9'(B_COLS))}, 1);
         if (b_q.size() == 0) begin
            check("big_unexpected_write", 1, 0);
         end else begin
            wr_t e;
            e = b_q.pop_front();
            check("big_write", {7'd0, b_wrow, 7'd0, b_wcol, b_wdata},
                  {7'd0, 9'(e.r), 7'd0, 9'(e.c), 8'(e.d)});
         end
         b_writes++;
         b_last_r = int'(b_wrow);
         b_last_c = int'(b_wcol);
      end
   end

   // Called on a negedge; pulses start and confirms the loader entered LOAD
   task automatic small_start();
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      s_idx   = 0;
      check("small_start_busy", {31'd0, s_busy}, 1);
      check("small_start_ready", {31'd0, s_ready}, 1);
      check("small_start_done_clear", {31'd0, s_done}, 0);
   endtask

   // pattern 0: always valid, data=index; 1: toggle, data=index; 2: random valid/data; 3: random, first byte 0xAA
   task automatic run_small(input int pattern, input int stop, input int start_at);
      logic pulsed = 1'b0;
      for (int cyc = 0; cyc < 400 && s_idx < stop; cyc++) begin
         case (pattern)
            0: begin s_valid = 1'b1; s_data = 8'(s_idx); end
            1: begin s_valid = (cyc % 2) == 0; s_data = 8'(s_idx); end
            2: begin s_valid = 1'($urandom_range(0, 1)); s_data = 8'($urandom); end
            default: begin
               s_valid = (s_idx == 0) ? 1'b1 : 1'($urandom_range(0, 1));
               s_data  = (s_idx == 0) ? 8'hAA : 8'($urandom);
            end
         endcase
         s_start = (s_idx == start_at) && !pulsed;
         if (s_start) pulsed = 1'b1;
         if (s_valid && s_ready) begin
            s_q.push_back('{r: s_idx / S_COLS, c: s_idx % S_COLS, d: int'(s_data)});
            s_idx++;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_start = 1'b0;
      check("small_beats_issued", s_idx, stop);
   endtask

   task automatic wait_small_done(input int base);
      for (int i = 0; i < 20 && !s_done; i++) @(negedge clk);
      @(negedge clk);
      check("small_frame_done", {31'd0, s_done}, 1);
      check("small_write_count", s_writes - base, S_ROWS * S_COLS);
      check("small_queue_drained", s_q.size(), 0);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, s_ready}, 0);
      check("rst_we", {31'd0, s_we}, 0);
      check("rst_data", {24'd0, s_wdata}, 0);
      check("rst_addr", {14'd0, s_wrow, s_wcol}, 0);
      check("rst_busy_done", {30'd0, s_busy, s_done}, 0);
      check("big_rst_outputs", {28'd0, b_ready, b_we, b_busy, b_done}, 0);
      #1 s_rst_n = 1'b1; b_rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready_low", {31'd0, s_ready}, 0);

      // Frame A: continuous beats, data = index
      base = s_writes;
      small_start();
      run_small(0, 12, -1);
      wait_small_done(base);

      // Frame B: in_valid toggling every cycle
      base = s_writes;
      small_start();
      run_small(1, 12, -1);
      wait_small_done(base);

      // Frame C: random gaps, start pulse at pixel 5 must be ignored
      base = s_writes;
      small_start();
      run_small(2, 12, 5);
      wait_small_done(base);
      repeat (4) @(negedge clk);
      check("single_frame_done", {31'd0, s_done}, 1);
      check("no_extra_writes", s_writes - base, 12);

      // Frame D: reset after pixel 7, then a fresh full frame
      small_start();
      run_small(0, 8, -1);
      #1 s_rst_n = 1'b0;
      #1;
      check("async_rst_we", {31'd0, s_we}, 0);
      check("async_rst_busy", {31'd0, s_busy}, 0);
      check("async_rst_ready", {31'd0, s_ready}, 0);
      check("async_rst_addr", {14'd0, s_wrow, s_wcol}, 0);
      @(negedge clk);
      #1 s_rst_n = 1'b1;
      @(negedge clk);
      base = s_writes;
      small_start();
      run_small(2, 12, -1);
      wait_small_done(base);

      // DONE: offered bytes are refused, then restart takes 0xAA first
      s_valid = 1'b1;
      s_data  = 8'hAA;
      base = s_writes;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("done_refuses_ready", {31'd0, s_ready}, 0);
         check("done_no_write", {31'd0, s_we}, 0);
      end
      check("done_no_write_count", s_writes - base, 0);
      small_start();
      run_small(3, 12, -1);
      wait_small_done(base);

      // Default geometry, full throughput, pixel = (row+col) mod 256
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int cyc = 0; cyc < 70000 && b_idx < B_ROWS * B_COLS; cyc++) begin
         b_valid = 1'b1;
         b_data  = 8'(((b_idx / B_COLS) + (b_idx % B_COLS)) % 256);
         if (b_ready) begin
            b_q.push_back('{r: b_idx / B_COLS, c: b_idx % B_COLS, d: int'(b_data)});
            b_idx++;
         end
         @(negedge clk);
      end
      b_valid = 1'b0;
      for (int i = 0; i < 10 && !b_done; i++) @(negedge clk);
      check("big_frame_done", {31'd0, b_done}, 1);
      check("big_write_count", b_writes, B_ROWS * B_COLS);
      check("big_last_row", b_last_r, B_ROWS - 1);
      check("big_last_col", b_last_c, B_COLS - 1);
      check("big_queue_drained", b_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
